// File: rtl/lvt_write_scheduler.sv
// Write-side feeder for the 2W/2R LVT memory: per-port request FIFOs, dual-lane issue
// with same-address serialisation under alternating priority, and read-hazard flags.
module lvt_write_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      wrReqValid,
    output logic [1:0]                      wrReqReady,
    input  logic [1:0][ADDR_WIDTH-1:0]      wrReqAddr,
    input  logic [1:0][DATA_WIDTH-1:0]      wrReqData,
    input  logic                            hold,
    output logic [1:0][ADDR_WIDTH-1:0]      wrAddr,
    output logic [1:0][DATA_WIDTH-1:0]      dIn,
    output logic [1:0]                      wren,
    input  logic [1:0][ADDR_WIDTH-1:0]      rdAddr,
    output logic [1:0]                      rdHazard,
    output logic [15:0]                     collCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]              r_fifo_addr [2][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]              r_fifo_data [2][FIFO_DEPTH];
    logic [1:0][PTR_W-1:0]              r_wr_ptr;
    logic [1:0][PTR_W-1:0]              r_rd_ptr;
    logic [1:0][CNT_W-1:0]              r_count;
    logic                               r_coll_pri;

    logic [1:0]                         w_head_valid;
    logic [1:0]                         w_push;
    logic [1:0]                         w_issue;
    logic [1:0][ADDR_WIDTH-1:0]         w_head_addr;
    logic [1:0][DATA_WIDTH-1:0]         w_head_data;
    logic [1:0][FIFO_DEPTH-1:0]         w_live;
    logic                               w_coll;

    genvar gi, ge;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign wrReqReady[gi]   = r_count[gi] < DEPTH_C;
            assign w_head_valid[gi] = r_count[gi] != '0;
            assign w_head_addr[gi]  = r_fifo_addr[gi][r_rd_ptr[gi]];
            assign w_head_data[gi]  = r_fifo_data[gi][r_rd_ptr[gi]];
            assign w_push[gi]       = wrReqValid[gi] & wrReqReady[gi];
            // An entry is live when its distance from the read pointer is below the fill count.
            for (ge = 0; ge < FIFO_DEPTH; ge++) begin : g_entry
                logic [PTR_W-1:0] w_offset;
                assign w_offset       = PTR_W'(ge) - r_rd_ptr[gi];
                assign w_live[gi][ge] = {1'b0, w_offset} < r_count[gi];
            end
        end
    endgenerate

    assign w_coll = (&w_head_valid) && (w_head_addr[0] == w_head_addr[1]);

    always_comb begin
        w_issue = '0;
        if (!hold) begin
            if (w_coll) begin
                w_issue = r_coll_pri ? 2'b10 : 2'b01;
            end else begin
                w_issue = w_head_valid;
            end
        end
    end

    // Hazard covers both queued writes and the writes currently on the memory ports.
    always_comb begin
        rdHazard = '0;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (wren[p] && (wrAddr[p] == rdAddr[r])) begin
                    rdHazard[r] = 1'b1;
                end
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    if (w_live[p][e] && (r_fifo_addr[p][e] == rdAddr[r])) begin
                        rdHazard[r] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
                r_fifo_addr[p][r_wr_ptr[p]] <= wrReqAddr[p];
                r_fifo_data[p][r_wr_ptr[p]] <= wrReqData[p];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            wren       <= '0;
            wrAddr     <= '0;
            dIn        <= '0;
            r_coll_pri <= 1'b0;
            collCount  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_push[p]) begin
                    r_wr_ptr[p] <= r_wr_ptr[p] + PTR_W'(1);
                end
                if (w_issue[p]) begin
                    r_rd_ptr[p] <= r_rd_ptr[p] + PTR_W'(1);
                    wrAddr[p]   <= w_head_addr[p];
                    dIn[p]      <= w_head_data[p];
                end
                r_count[p] <= r_count[p] + CNT_W'(w_push[p]) - CNT_W'(w_issue[p]);
            end
            wren <= w_issue;
            if (!hold && w_coll) begin
                r_coll_pri <= ~r_coll_pri;
                if (collCount != 16'hFFFF) begin
                    collCount <= collCount + 16'd1;
                end
            end
        end
    end

endmodule
